// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte streams.
// A grant lasts one packet, cut short after MAXLEN bytes or GAPLIM idle cycles.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int MAXLEN = 64,
    parameter int GAPLIM = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   grant_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    input  logic              tx_done_i,
    output logic              busy_o
);
    localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      MAXLEN_C  = 8'(MAXLEN);
    localparam logic [15:0]     GAP_LAST  = 16'(GAPLIM - 1);
    localparam logic [IW-1:0]   PTR_RESET = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   last_ptr_q, last_ptr_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [15:0]     gap_cnt_q, gap_cnt_d;
    logic            last_q, last_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;

    logic            drop_grant;
    logic            xfer;
    logic [IW-1:0]   pick_idx;
    logic [7:0]      data_sel;

    // First requester strictly after ptr, wrapping; only meaningful when some valid bit is set.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IW-1:0]   ptr);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        logic          found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign pick_idx = rr_pick(req_valid_i, last_ptr_q);
    assign data_sel = req_data_i[{gidx_q, 3'b000} +: 8];
    assign xfer     = (state_q == SEND) && req_valid_i[gidx_q] && !tx_busy_i;

    assign req_ready_o = (state_q == SEND && !tx_busy_i) ? (grant_q & req_valid_i) : '0;
    assign grant_o     = grant_q;
    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        // NOTE: every _d starts as its _q so no branch leaves a signal unassigned and infers a latch.
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_ptr_d = last_ptr_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        drop_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    gidx_d    = pick_idx;
                    grant_d   = ONE_HOT0 << pick_idx;
                    gap_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    tx_data_d  = data_sel;
                    tx_start_d = 1'b1;
                    last_d     = req_last_i[gidx_q];
                    byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
                    gap_cnt_d  = '0;
                    state_d    = WAIT;
                end else if (!tx_busy_i) begin
                    // Owner has nothing to offer; a busy transmitter is not counted as a gap.
                    if (gap_cnt_q >= GAP_LAST) begin
                        drop_grant = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end
                end
            end
            WAIT: begin
                if (tx_done_i) begin
                    if (!last_q && byte_cnt_q < MAXLEN_C) begin
                        gap_cnt_d = '0;
                        state_d   = SEND;
                    end else begin
                        drop_grant = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Release always passes through IDLE, so re-arbitration costs at least one cycle.
        if (drop_grant) begin
            grant_d    = '0;
            last_ptr_d = gidx_q;
            byte_cnt_d = '0;
            gap_cnt_d  = '0;
            last_d     = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_ptr_q <= PTR_RESET;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            last_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_ptr_q <= last_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a transmitter model and a
// scoreboard of expected (requester, byte) transfers checked at every TXSTART.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NREQ   = 4;
    localparam int MAXLEN = 64;
    localparam int GAPLIM = 16;
    localparam int TXLAT  = 3;
    localparam int QD     = 128;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NREQ-1:0]   req_valid_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ-1:0]   grant_o;
    logic [7:0]        tx_data_o;
    logic              tx_start_o;
    logic              tx_busy_i;
    logic              tx_done_i;
    logic              busy_o;

    uart_tx_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN), .GAPLIM(GAPLIM)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .tx_data_o   (tx_data_o),
        .tx_start_o  (tx_start_o),
        .tx_busy_i   (tx_busy_i),
        .tx_done_i   (tx_done_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    logic [8:0] rmem [NREQ][QD];
    int         rhead [NREQ];
    int         rtail [NREQ];
    exp_t       sb [$];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] hold_data;
    logic       model_busy, model_done, busy_force;
    int         xm_cnt;
    int         done_cnt, start_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        rmem[r][rtail[r]] = {last, d};
        rtail[r]++;
    endtask

    task automatic expect_tx(input int r, input logic [7:0] d);
        exp_t e;
        e.req  = r;
        e.data = d;
        sb.push_back(e);
    endtask

    function automatic logic queues_empty();
        for (int i = 0; i < NREQ; i++)
            if (rhead[i] != rtail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rhead[i] != rtail[i]) begin
                req_valid_i[i]       = 1'b1;
                req_data_i[8*i +: 8] = rmem[i][rhead[i]][7:0];
                req_last_i[i]        = rmem[i][rhead[i]][8];
            end else begin
                req_valid_i[i]       = 1'b0;
                req_data_i[8*i +: 8] = 8'h00;
                req_last_i[i]        = 1'b0;
            end
        end
        tx_busy_i = model_busy | busy_force;
        tx_done_i = model_done;
    endtask

    task automatic monitor();
        exp_t e;
        chk("ready_within_grant", 32'(req_ready_o & ~grant_o), 32'h0);
        if (tx_done_i) done_cnt++;
        if (tx_start_o) begin
            start_cnt++;
            chk("txstart_expected", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                hold_data = e.data;
                chk("tx_grant", 32'(grant_o), 32'(1 << e.req));
            end
        end
        chk("tx_data", 32'(tx_data_o), 32'(hold_data));
    endtask

    // One clock: sample handshakes at the negedge, update drivers just after the posedge,
    // return at the next negedge with fresh DUT outputs checked.
    task automatic tick();
        logic [NREQ-1:0] hs;
        logic            st;
        hs = req_valid_i & req_ready_o;
        st = tx_start_o;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (hs[i]) rhead[i]++;
        model_done = 1'b0;
        if (st) begin
            model_busy = 1'b1;
            xm_cnt     = TXLAT;
        end else if (xm_cnt > 0) begin
            xm_cnt--;
            if (xm_cnt == 0) begin
                model_busy = 1'b0;
                model_done = 1'b1;
            end
        end
        drive();
        @(negedge clk_i);
        monitor();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_txstart", 32'(tx_start_o), 32'h0);
        chk("rst_txdata", 32'(tx_data_o), 32'h0);
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        for (int i = 0; i < NREQ; i++) rhead[i] = rtail[i];
        sb.delete();
        hold_data = 8'h00;
        drive();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int   n;
        logic fin;
        n = 0;
        fin = 1'b0;
        while (!fin && n < bound) begin
            tick();
            n++;
            fin = (sb.size() == 0) && (busy_o == 1'b0) && queues_empty();
        end
        chk(tag, 32'(fin), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, base;
        rst_i      = 1'b1;
        busy_force = 1'b0;
        model_busy = 1'b0;
        model_done = 1'b0;
        xm_cnt     = 0;
        hold_data  = 8'h00;
        done_cnt   = 0;
        start_cnt  = 0;
        for (int i = 0; i < NREQ; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        drive();
        do_reset();

        // Three-byte packet from requester 0.
        push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h43, 1'b1);
        expect_tx(0, 8'h41); expect_tx(0, 8'h42); expect_tx(0, 8'h43);
        drive();
        tick();
        chk("s1_grant_at_1", 32'(grant_o), 32'h1);
        chk("s1_busy_at_1", 32'(busy_o), 32'h1);
        chk("s1_no_start_at_1", 32'(tx_start_o), 32'h0);
        tick();
        chk("s1_start_at_2", 32'(tx_start_o), 32'h1);
        done_cnt = 0;
        n = 0;
        while (done_cnt < 3 && n < 200) begin
            chk("s1_grant_held", 32'(grant_o), 32'h1);
            tick();
            n++;
        end
        chk("s1_done_count", 32'(done_cnt), 32'd3);
        chk("s1_grant_before_release", 32'(grant_o), 32'h1);
        tick();
        chk("s1_release_grant", 32'(grant_o), 32'h0);
        chk("s1_release_busy", 32'(busy_o), 32'h0);
        chk("s1_all_sent", 32'(sb.size()), 32'h0);

        // Requesters 1 and 3 alternate single-byte packets.
        do_reset();
        push_byte(1, 8'h11, 1'b1); push_byte(1, 8'h12, 1'b1);
        push_byte(3, 8'h31, 1'b1); push_byte(3, 8'h32, 1'b1);
        expect_tx(1, 8'h11); expect_tx(3, 8'h31); expect_tx(1, 8'h12); expect_tx(3, 8'h32);
        drive();
        n = 0;
        while (!(sb.size() == 0 && busy_o == 1'b0) && n < 300) begin
            chk("s2_no_ready_0_2", 32'(req_ready_o & 4'b0101), 32'h0);
            tick();
            n++;
        end
        chk("s2_finished", 32'(sb.size()), 32'h0);

        // 70 bytes without LAST: MAXLEN cut, others served, then requester 2 resumes.
        do_reset();
        for (int i = 0; i < 70; i++) push_byte(2, 8'(i + 1), 1'b0);
        for (int i = 0; i < 64; i++) expect_tx(2, 8'(i + 1));
        drive();
        tick();
        chk("s3_grant2", 32'(grant_o), 32'h4);
        push_byte(3, 8'hA3, 1'b1);
        push_byte(0, 8'hA0, 1'b1);
        expect_tx(3, 8'hA3);
        expect_tx(0, 8'hA0);
        for (int i = 64; i < 70; i++) expect_tx(2, 8'(i + 1));
        drive();
        wait_idle(3000, "s3_finished");

        // Requester 0 goes quiet after one byte: gap timeout, then requester 1.
        do_reset();
        push_byte(0, 8'h10, 1'b0);
        expect_tx(0, 8'h10);
        drive();
        n = 0;
        while (tx_done_i !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("s4_done_seen", 32'(tx_done_i), 32'h1);
        push_byte(1, 8'h20, 1'b1);
        expect_tx(1, 8'h20);
        drive();
        tick();
        cnt = 0;
        while (grant_o === 4'b0001 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("s4_gap_cycles", 32'(cnt), 32'(GAPLIM));
        chk("s4_idle_after_gap", 32'(grant_o), 32'h0);
        tick();
        chk("s4_next_grant", 32'(grant_o), 32'h2);
        wait_idle(200, "s4_finished");

        // Transmitter busy stalls the transfer without timing out.
        do_reset();
        busy_force = 1'b1;
        push_byte(0, 8'h55, 1'b1);
        expect_tx(0, 8'h55);
        drive();
        tick();
        chk("s5_grant", 32'(grant_o), 32'h1);
        for (int i = 0; i < 20; i++) begin
            chk("s5_stall_ready", 32'(req_ready_o), 32'h0);
            chk("s5_stall_start", 32'(tx_start_o), 32'h0);
            chk("s5_stall_grant", 32'(grant_o), 32'h1);
            tick();
        end
        busy_force = 1'b0;
        drive();
        #1;
        chk("s5_ready_when_free", 32'(req_ready_o), 32'h1);
        tick();
        chk("s5_start_when_free", 32'(tx_start_o), 32'h1);
        wait_idle(200, "s5_finished");

        // Reset in the middle of a 5-byte packet.
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(2, 8'hC0 + 8'(i), (i == 4));
        expect_tx(2, 8'hC0);
        expect_tx(2, 8'hC1);
        drive();
        base = start_cnt;
        n = 0;
        while (start_cnt < base + 2 && n < 100) begin
            tick();
            n++;
        end
        chk("s6_two_starts", 32'(start_cnt - base), 32'd2);
        tick();
        chk("s6_in_wait_grant", 32'(grant_o), 32'h4);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk("s6_idle_busy", 32'(busy_o), 32'h0);
            chk("s6_idle_grant", 32'(grant_o), 32'h0);
            tick();
        end
        push_byte(3, 8'hD3, 1'b1);
        push_byte(0, 8'hD0, 1'b1);
        expect_tx(0, 8'hD0);
        expect_tx(3, 8'hD3);
        drive();
        tick();
        chk("s6_first_grant", 32'(grant_o), 32'h1);
        wait_idle(200, "s6_finished");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
